// File: rtl/decode_pkg.sv
// Shared types for the RV32 decode stage: opcode/funct encodings, instruction
// classes and the registered decode record.
package decode_pkg;

  typedef enum logic [6:0] {
    OPC_LUI      = 7'b0110111,
    OPC_AUIPC    = 7'b0010111,
    OPC_JAL      = 7'b1101111,
    OPC_JALR     = 7'b1100111,
    OPC_BRANCH   = 7'b1100011,
    OPC_LOAD     = 7'b0000011,
    OPC_STORE    = 7'b0100011,
    OPC_OP_IMM   = 7'b0010011,
    OPC_OP       = 7'b0110011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_SYSTEM   = 7'b1110011
  } opcode_e;

  typedef enum logic [2:0] {
    F3_ADD_SUB = 3'b000,
    F3_SLL     = 3'b001,
    F3_SLT     = 3'b010,
    F3_SLTU    = 3'b011,
    F3_XOR     = 3'b100,
    F3_SRL_SRA = 3'b101,
    F3_OR      = 3'b110,
    F3_AND     = 3'b111
  } funct3_e;

  typedef enum logic [6:0] {
    F7_BASE = 7'b0000000,
    F7_ALT  = 7'b0100000
  } funct7_e;

  typedef enum logic [3:0] {
    LUI      = 4'd0,
    AUIPC    = 4'd1,
    JAL      = 4'd2,
    JALR     = 4'd3,
    OP_IMM   = 4'd4,
    OP_REG   = 4'd5,
    BRANCH   = 4'd6,
    LOAD     = 4'd7,
    STORE    = 4'd8,
    MISC_MEM = 4'd9,
    SYSTEM   = 4'd10,
    INVALID  = 4'd11
  } inst_class_e;

  typedef struct packed {
    logic [31:0] pc;
    inst_class_e cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        illegal;
  } decoded_t;

  function automatic logic reg_out_of_range(input logic [4:0] idx, input int count);
    return int'({27'b0, idx}) >= count;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface decode_stage_if;
  import decode_pkg::*;

  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  inst_class_e out_class;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [31:0] out_imm;
  logic        out_illegal;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_class, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_class, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_illegal
  );

endinterface

// File: rtl/decode_fields.sv
// Combinational RV32 field extraction, immediate selection and legality check.
module decode_fields
  import decode_pkg::*;
#(
  parameter int REG_COUNT    = 16,
  parameter bit ALLOW_SYSTEM = 1'b1,
  parameter bit ALLOW_FENCE  = 1'b1
) (
  input  logic [31:0] instr,
  output inst_class_e cls,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] imm,
  output logic        illegal
);

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_fmt;
  inst_class_e cls_raw;
  logic        use_rd, use_rs1, use_rs2, enc_bad, reg_bad;

  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    cls_raw = INVALID;
    imm_fmt = '0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    enc_bad = 1'b0;
    case (instr[6:0])
      OPC_LUI:   begin cls_raw = LUI;   imm_fmt = imm_u; use_rd = 1'b1; end
      OPC_AUIPC: begin cls_raw = AUIPC; imm_fmt = imm_u; use_rd = 1'b1; end
      OPC_JAL:   begin cls_raw = JAL;   imm_fmt = imm_j; use_rd = 1'b1; end
      OPC_JALR: begin
        cls_raw = JALR; imm_fmt = imm_i; use_rd = 1'b1; use_rs1 = 1'b1;
        enc_bad = (funct3 != 3'b000);
      end
      OPC_OP_IMM: begin
        cls_raw = OP_IMM; imm_fmt = imm_i; use_rd = 1'b1; use_rs1 = 1'b1;
        if (funct3 == F3_SLL)
          enc_bad = (funct7 != F7_BASE);
        else if (funct3 == F3_SRL_SRA)
          enc_bad = !(funct7 == F7_BASE || funct7 == F7_ALT);
      end
      OPC_OP: begin
        cls_raw = OP_REG; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        enc_bad = !(funct7 == F7_BASE ||
                    (funct7 == F7_ALT && (funct3 == F3_ADD_SUB || funct3 == F3_SRL_SRA)));
      end
      OPC_BRANCH: begin
        cls_raw = BRANCH; imm_fmt = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1;
        enc_bad = (funct3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        cls_raw = LOAD; imm_fmt = imm_i; use_rd = 1'b1; use_rs1 = 1'b1;
        enc_bad = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        cls_raw = STORE; imm_fmt = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1;
        enc_bad = (funct3 > 3'b010);
      end
      // FENCE/SYSTEM carry I-format fields; only the parameter gates apply
      OPC_MISC_MEM: begin
        cls_raw = MISC_MEM; imm_fmt = imm_i; use_rd = 1'b1; use_rs1 = 1'b1;
        enc_bad = !ALLOW_FENCE && (funct3 == 3'b000);
      end
      OPC_SYSTEM: begin
        cls_raw = SYSTEM; imm_fmt = imm_i; use_rd = 1'b1; use_rs1 = 1'b1;
        enc_bad = !ALLOW_SYSTEM;
      end
      default: enc_bad = 1'b1;
    endcase
  end

  assign reg_bad = (use_rd  && reg_out_of_range(rd,  REG_COUNT)) ||
                   (use_rs1 && reg_out_of_range(rs1, REG_COUNT)) ||
                   (use_rs2 && reg_out_of_range(rs2, REG_COUNT));

  assign illegal = enc_bad || reg_bad || (instr[1:0] != 2'b11);
  assign cls     = illegal ? INVALID : cls_raw;
  assign imm     = illegal ? 32'b0 : imm_fmt;

endmodule

// File: rtl/decode_stage.sv
// Registered RV32 decode stage with a two-entry elastic buffer (output + skid).
//   state | meaning
//   EMPTY | nothing buffered, out_valid=0
//   ONE   | output register holds the oldest instruction
//   TWO   | output and skid registers both full, in_ready=0
module decode_stage
  import decode_pkg::*;
#(
  parameter int REG_COUNT    = 16,
  parameter bit ALLOW_SYSTEM = 1'b1,
  parameter bit ALLOW_FENCE  = 1'b1
) (
  input logic           clk,
  input logic           reset,
  decode_stage_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} buf_state_e;

  buf_state_e  state, state_nxt;
  decoded_t    dec, out_q, skid_q;
  inst_class_e f_cls;
  logic [4:0]  f_rd, f_rs1, f_rs2;
  logic [2:0]  f_funct3;
  logic [6:0]  f_funct7;
  logic [31:0] f_imm;
  logic        f_illegal;
  logic        accept, drain, load_out_in, load_out_skid, load_skid;

  decode_fields #(
    .REG_COUNT    (REG_COUNT),
    .ALLOW_SYSTEM (ALLOW_SYSTEM),
    .ALLOW_FENCE  (ALLOW_FENCE)
  ) u_fields (
    .instr   (bus.in_instr),
    .cls     (f_cls),
    .rd      (f_rd),
    .rs1     (f_rs1),
    .rs2     (f_rs2),
    .funct3  (f_funct3),
    .funct7  (f_funct7),
    .imm     (f_imm),
    .illegal (f_illegal)
  );

  assign dec = '{pc: bus.in_pc, cls: f_cls, rd: f_rd, rs1: f_rs1, rs2: f_rs2,
                 funct3: f_funct3, funct7: f_funct7, imm: f_imm, illegal: f_illegal};

  assign accept = bus.in_valid && bus.in_ready;
  assign drain  = bus.out_valid && bus.out_ready;

  always_comb begin
    state_nxt     = state;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      EMPTY: if (accept) begin state_nxt = ONE; load_out_in = 1'b1; end
      ONE: begin
        if (accept && drain)  load_out_in = 1'b1;
        else if (accept)      begin state_nxt = TWO; load_skid = 1'b1; end
        else if (drain)       state_nxt = EMPTY;
      end
      TWO: if (drain) begin state_nxt = ONE; load_out_skid = 1'b1; end
      default: state_nxt = EMPTY;
    endcase
    // flush wins over any same-cycle transfer; the offered word is dropped
    if (bus.flush) begin
      state_nxt     = EMPTY;
      load_out_in   = 1'b0;
      load_out_skid = 1'b0;
      load_skid     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EMPTY;
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      state <= state_nxt;
      if (load_out_in)        out_q <= dec;
      else if (load_out_skid) out_q <= skid_q;
      if (load_skid)          skid_q <= dec;
    end
  end

  assign bus.in_ready    = (state != TWO);
  assign bus.out_valid   = (state != EMPTY);
  assign bus.out_pc      = out_q.pc;
  assign bus.out_class   = out_q.cls;
  assign bus.out_rd      = out_q.rd;
  assign bus.out_rs1     = out_q.rs1;
  assign bus.out_rs2     = out_q.rs2;
  assign bus.out_funct3  = out_q.funct3;
  assign bus.out_funct7  = out_q.funct7;
  assign bus.out_imm     = out_q.imm;
  assign bus.out_illegal = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: RV32E (all opcodes allowed) and RV32I (SYSTEM/FENCE
// gated) instances share stimulus and are checked against a queue model.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } txn_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        live = 1'b0;
  int          tests = 0;
  int          fails = 0;
  txn_t        q[$];
  logic [31:0] drained[$];
  logic [31:0] vec[$];

  always #5 clk = ~clk;

  decode_stage_if if16();
  decode_stage_if if32();

  assign if16.flush = flush;     assign if32.flush = flush;
  assign if16.in_valid = in_valid; assign if32.in_valid = in_valid;
  assign if16.in_instr = in_instr; assign if32.in_instr = in_instr;
  assign if16.in_pc = in_pc;     assign if32.in_pc = in_pc;
  assign if16.out_ready = out_ready; assign if32.out_ready = out_ready;

  decode_stage #(.REG_COUNT(16), .ALLOW_SYSTEM(1'b1), .ALLOW_FENCE(1'b1))
    dut16 (.clk(clk), .reset(reset), .bus(if16));
  decode_stage #(.REG_COUNT(32), .ALLOW_SYSTEM(1'b0), .ALLOW_FENCE(1'b0))
    dut32 (.clk(clk), .reset(reset), .bus(if32));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected decode from the ISA rules, immediates as two's-complement values
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc,
                                 input int regs, input bit sys_ok, input bit fence_ok);
    exp_t e;
    int   v, cls;
    bit   bad, urd, urs1, urs2;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = w[14:12]; f7 = w[31:25];
    bad = 0; urd = 0; urs1 = 0; urs2 = 0; cls = 11; v = 0;
    case (w[6:0])
      7'h37: begin cls = 0; v = int'(w[31:12]) * 4096; urd = 1; end
      7'h17: begin cls = 1; v = int'(w[31:12]) * 4096; urd = 1; end
      7'h6F: begin
        cls = 2; urd = 1;
        v = int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
        if (w[31]) v -= 1 << 20;
      end
      7'h67, 7'h13, 7'h03, 7'h0F, 7'h73: begin
        urd = 1; urs1 = 1;
        v = int'(w[31:20]); if (w[31]) v -= 4096;
        case (w[6:0])
          7'h67: begin cls = 3; bad = f3 != 0; end
          7'h13: begin
            cls = 4;
            if (f3 == 1) bad = f7 != 0;
            if (f3 == 5) bad = !(f7 == 0 || f7 == 7'h20);
          end
          7'h03: begin cls = 7; bad = !(f3 inside {0, 1, 2, 4, 5}); end
          7'h0F: begin cls = 9; bad = (f3 == 0) && !fence_ok; end
          default: begin cls = 10; bad = !sys_ok; end
        endcase
      end
      7'h33: begin
        cls = 5; urd = 1; urs1 = 1; urs2 = 1;
        bad = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
      end
      7'h63: begin
        cls = 6; urs1 = 1; urs2 = 1; bad = (f3 == 2 || f3 == 3);
        v = int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        if (w[31]) v -= 4096;
      end
      7'h23: begin
        cls = 8; urs1 = 1; urs2 = 1; bad = f3 > 2;
        v = int'(w[31:25]) * 32 + int'(w[11:7]); if (w[31]) v -= 4096;
      end
      default: bad = 1;
    endcase
    if (urd  && int'(w[11:7])  >= regs) bad = 1;
    if (urs1 && int'(w[19:15]) >= regs) bad = 1;
    if (urs2 && int'(w[24:20]) >= regs) bad = 1;
    if (w[1:0] != 2'b11) bad = 1;
    if (bad) begin cls = 11; v = 0; end
    e = '{pc: pc, cls: 4'(cls), rd: w[11:7], rs1: w[19:15], rs2: w[24:20],
          f3: f3, f7: f7, imm: 32'(v), ill: bad};
    return e;
  endfunction

  task automatic cmp(input string tag, input exp_t a, input logic ir, input logic ov,
                     input int regs, input bit sys_ok, input bit fence_ok);
    exp_t e;
    chk({tag, "_in_ready"}, 32'(ir), 32'(q.size() < 2));
    chk({tag, "_out_valid"}, 32'(ov), 32'(q.size() > 0));
    if (q.size() > 0) begin
      e = model(q[0].instr, q[0].pc, regs, sys_ok, fence_ok);
      chk({tag, "_pc"}, a.pc, e.pc);
      chk({tag, "_class"}, 32'(a.cls), 32'(e.cls));
      chk({tag, "_regs"}, {17'b0, a.rd, a.rs1, a.rs2}, {17'b0, e.rd, e.rs1, e.rs2});
      chk({tag, "_funct"}, {22'b0, a.f3, a.f7}, {22'b0, e.f3, e.f7});
      chk({tag, "_imm"}, a.imm, e.imm);
      chk({tag, "_illegal"}, 32'(a.ill), 32'(e.ill));
    end
  endtask

  // Queue model of the buffer plus a log of what the 16-register DUT hands out
  always @(posedge clk) begin
    if (reset || flush) begin
      q.delete();
    end else begin
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (in_valid && q.size() < 2 + ((q.size() > 0 && out_ready) ? -1 : 0))
        q.push_back('{instr: in_instr, pc: in_pc});
    end
    if (!reset && !flush && if16.out_valid && out_ready) drained.push_back(if16.out_pc);
    if (reset) live <= 1'b1;
  end

  always @(negedge clk) begin
    if (live) begin
      cmp("d16", '{if16.out_pc, 4'(if16.out_class), if16.out_rd, if16.out_rs1, if16.out_rs2,
                   if16.out_funct3, if16.out_funct7, if16.out_imm, if16.out_illegal},
          if16.in_ready, if16.out_valid, 16, 1'b1, 1'b1);
      cmp("d32", '{if32.out_pc, 4'(if32.out_class), if32.out_rd, if32.out_rs1, if32.out_rs2,
                   if32.out_funct3, if32.out_funct7, if32.out_imm, if32.out_illegal},
          if32.in_ready, if32.out_valid, 32, 1'b0, 1'b0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    int n = 0;
    in_valid = 1'b1; in_instr = instr; in_pc = pc;
    while (!if16.in_ready && n < 20) begin step(); n++; end
    if (n >= 20) begin
      tests++; fails++;
      $display("FAIL send_timeout: in_ready stuck 0 for pc %h", pc);
    end
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    step(); step();
    reset = 1'b0;
    chk("rst_out_valid", 32'(if16.out_valid), 0);
    chk("rst_in_ready", 32'(if16.in_ready), 1);
    chk("rst_out_pc", if16.out_pc, 0);

    // model pins
    chk("pin_addi_imm", model(32'hFFF30293, 0, 16, 1, 1).imm, 32'hFFFFFFFF);
    chk("pin_beq_imm", model(32'h80000063, 0, 16, 1, 1).imm, 32'hFFFFF000);
    chk("pin_jal_imm", model(32'h001000EF, 0, 16, 1, 1).imm, 32'h00000800);
    chk("pin_sw_imm", model({7'h7F, 5'd3, 5'd2, 3'b010, 5'h1C, 7'h23}, 0, 16, 1, 1).imm, 32'hFFFFFFFC);
    chk("pin_add17_ill", 32'(model(32'h002088B3, 0, 16, 1, 1).ill), 1);

    out_ready = 1'b1;
    send(32'hFFF30293, 32'h0000_0040);
    chk("addi_valid", 32'(if16.out_valid), 1);
    chk("addi_class", 32'(if16.out_class), 4);
    chk("addi_rd_rs1", {22'b0, if16.out_rd, if16.out_rs1}, {22'b0, 5'd5, 5'd6});
    chk("addi_imm", if16.out_imm, 32'hFFFFFFFF);
    chk("addi_illegal", 32'(if16.out_illegal), 0);

    send(32'h002088B3, 32'h0000_0044);
    chk("add17_rv32e_ill", 32'(if16.out_illegal), 1);
    chk("add17_rv32e_class", 32'(if16.out_class), 11);
    chk("add17_rv32e_imm", if16.out_imm, 0);
    chk("add17_rv32e_rd", 32'(if16.out_rd), 17);
    chk("add17_rv32i_ill", 32'(if32.out_illegal), 0);
    chk("add17_rv32i_class", 32'(if32.out_class), 5);

    send(32'h80000063, 32'h0000_0048);
    chk("beq_imm", if16.out_imm, 32'hFFFFF000);
    send(32'h001000EF, 32'h0000_004C);
    chk("jal_imm", if16.out_imm, 32'h00000800);
    chk("jal_rd", 32'(if16.out_rd), 1);
    step();

    // backpressure: A, B buffered, C waits
    drained.delete();
    out_ready = 1'b0;
    send(32'h00100093, 32'h100);
    send(32'h00200113, 32'h104);
    in_valid = 1'b1; in_instr = 32'h00300193; in_pc = 32'h108;
    step();
    chk("bp_in_ready", 32'(if16.in_ready), 0);
    chk("bp_hold_pc", if16.out_pc, 32'h100);
    step();
    chk("bp_hold_pc2", if16.out_pc, 32'h100);
    out_ready = 1'b1;
    send(32'h00300193, 32'h108);
    repeat (3) step();
    chk("bp_count", drained.size(), 3);
    if (drained.size() == 3) begin
      chk("bp_order0", drained[0], 32'h100);
      chk("bp_order1", drained[1], 32'h104);
      chk("bp_order2", drained[2], 32'h108);
    end

    // flush in ONE with a word accepted the same cycle, then flush in TWO
    drained.delete();
    out_ready = 1'b0;
    send(32'h00400213, 32'h200);
    in_valid = 1'b1; in_instr = 32'h00500293; in_pc = 32'h204; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush1_out_valid", 32'(if16.out_valid), 0);
    send(32'h00600313, 32'h208);
    send(32'h00700393, 32'h20C);
    in_valid = 1'b1; in_instr = 32'h00800413; in_pc = 32'h210; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush2_out_valid", 32'(if16.out_valid), 0);
    chk("flush2_in_ready", 32'(if16.in_ready), 1);
    out_ready = 1'b1;
    repeat (3) step();
    chk("flush_none_out", drained.size(), 0);

    // reset mid-stream in TWO
    out_ready = 1'b0;
    send(32'hFFF30293, 32'h300);
    send(32'h80000063, 32'h304);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst_out_valid", 32'(if16.out_valid), 0);
    chk("mrst_in_ready", 32'(if16.in_ready), 1);
    chk("mrst_out_pc", if16.out_pc, 0);
    chk("mrst_out_imm", if16.out_imm, 0);
    chk("mrst_fields", {2'b0, 4'(if16.out_class), if16.out_rd, if16.out_rs1, if16.out_rs2,
                        if16.out_funct3, if16.out_funct7, if16.out_illegal}, 0);

    // mixed legal/illegal stream under intermittent backpressure
    vec = '{
      {7'h20, 5'd5, 5'd4, 3'b000, 5'd3, 7'h33},
      {7'h20, 5'd2, 5'd1, 3'b110, 5'd3, 7'h33},
      {7'h20, 5'd3, 5'd2, 3'b101, 5'd1, 7'h13},
      {7'h20, 5'd3, 5'd2, 3'b001, 5'd1, 7'h13},
      {7'h01, 5'd3, 5'd2, 3'b101, 5'd1, 7'h13},
      {12'd8, 5'd2, 3'b010, 5'd1, 7'h03},
      {12'd8, 5'd2, 3'b011, 5'd1, 7'h03},
      {12'hFFF, 5'd3, 3'b100, 5'd9, 7'h03},
      {7'h7F, 5'd3, 5'd2, 3'b010, 5'h1C, 7'h23},
      {7'h00, 5'd3, 5'd2, 3'b011, 5'h04, 7'h23},
      {7'h00, 5'd2, 5'd1, 3'b010, 5'h08, 7'h63},
      {7'h00, 5'd20, 5'd1, 3'b001, 5'h08, 7'h63},
      {12'd0, 5'd5, 3'b000, 5'd1, 7'h67},
      {12'd0, 5'd5, 3'b001, 5'd1, 7'h67},
      {20'h12345, 5'd10, 7'h37},
      {20'hABCDE, 5'd20, 7'h17},
      32'h00000073,
      32'h0FF0000F,
      32'h00004501,
      32'h0000007F,
      {12'd0, 5'd31, 3'b010, 5'd5, 7'h03},
      {12'h800, 5'd7, 3'b010, 5'd8, 7'h13}
    };
    for (int i = 0; i < vec.size(); i++) begin
      out_ready = (i % 3) != 2;
      send(vec[i], 32'h1000 + 32'(i * 4));
    end
    out_ready = 1'b1;
    repeat (4) step();
    chk("stream_drained_empty", 32'(if16.out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
